// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / serial frame transmitter pair.
// Holds the frame FSM state encoding and the fixed line levels.
package parity_pkg;

    localparam int PARITY_DATA_W = 16;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on
// the last cycle of each bit period. Held at zero while disabled.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_reg;

    // With CLKS_PER_BIT=1 the counter never leaves zero, so every enabled cycle ticks.
    assign tick = enable && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!enable || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, the supplied
// parity bit and a stop bit, each held for CLKS_PER_BIT clocks.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = PARITY_DATA_W,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_e         state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              parity_reg, parity_next;
    logic              tx_reg, tx_next;
    logic              done_reg, done_next;
    logic              tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(state_reg != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            idx_reg    <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= IDLE_LEVEL;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            idx_reg    <= idx_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        idx_next    = idx_reg;
        parity_next = parity_reg;
        done_next   = 1'b0;
        tx_next     = IDLE_LEVEL;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    shift_next  = in_data;
                    parity_next = in_parity;
                    state_next  = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    idx_next   = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(DATA_W - 1)) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The line level is registered, so it is derived from where the FSM is heading.
        case (state_next)
            START:   tx_next = START_BIT;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            STOP:    tx_next = STOP_BIT;
            default: tx_next = IDLE_LEVEL;
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign in_ready = ~busy;
    assign tx_out   = tx_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: a scoreboard queue of expected line
// levels is filled at each handshake and drained by a monitor while busy.
`timescale 1ns/100ps
module tb_parity_frame_tx;

    localparam int DATA_W    = 16;
    localparam int CPB       = 4;
    localparam int FRAME_LEN = (DATA_W + 3) * CPB;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              tx_out;
    logic              busy;
    logic              done;

    logic              v1;
    logic              ready1;
    logic [DATA_W-1:0] d1;
    logic              p1;
    logic              tx1;
    logic              busy1;
    logic              done1;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic exp1_q[$];

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_parity(in_parity), .tx_out(tx_out),
        .busy(busy), .done(done)
    );

    parity_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ready1),
        .in_data(d1), .in_parity(p1), .tx_out(tx1),
        .busy(busy1), .done(done1)
    );

    function automatic logic frame_bit(input logic [DATA_W-1:0] data, input logic par, input int i);
        if (i == 0)           return 1'b0;
        else if (i <= DATA_W) return data[i-1];
        else if (i == DATA_W + 1) return par;
        else                  return 1'b1;
    endfunction

    task automatic push_frame(input logic [DATA_W-1:0] data, input logic par);
        for (int b = 0; b < DATA_W + 3; b++)
            for (int c = 0; c < CPB; c++)
                exp_q.push_back(frame_bit(data, par, b));
        $display("frame sent: data=%h parity=%b", data, par);
    endtask

    // Scoreboard drain for the CLKS_PER_BIT=4 instance.
    always @(negedge clk) begin
        logic e;
        if (rst_n && busy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_bit: tx_out=%b but no bit expected", tx_out);
            end else begin
                e = exp_q.pop_front();
                if (tx_out !== e) begin
                    errors++;
                    $display("FAIL tx_bit: tx_out=%b expected %b (%0d left)", tx_out, e, exp_q.size());
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
        v1 = 1'b0; d1 = '0; p1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_out, in_ready, busy, done} !== 4'b1100) begin
                errors++;
                $display("FAIL idle: {tx,ready,busy,done}=%b expected 1100", {tx_out, in_ready, busy, done});
            end
        end
    endtask

    task automatic test_frame(input logic [DATA_W-1:0] data, input logic par, input bit change);
        @(negedge clk);
        in_data = data; in_parity = par; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        push_frame(data, par);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= FRAME_LEN; c++) begin
            if (change && c == 30) in_data = 16'hFFFF;
            if (change && c == 31) in_parity = ~par;
            checks++;
            if ({in_ready, done} !== 2'b00) begin
                errors++;
                $display("FAIL in_frame: cycle %0d {ready,done}=%b expected 00", c, {in_ready, done});
            end
            @(negedge clk);
        end
        checks++;
        if ({done, in_ready, tx_out, 32'(exp_q.size())} !== {3'b111, 32'd0}) begin
            errors++;
            $display("FAIL done_pulse: {done,ready,tx}=%b left=%0d expected 111 left=0", {done, in_ready, tx_out}, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b expected 0", done);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_data = 16'h000C; in_parity = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        push_frame(16'h000C, 1'b0);
        @(negedge clk);
        in_data = 16'h000E; in_parity = 1'b1;
        for (int c = 1; c <= FRAME_LEN; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready1: cycle %0d in_ready=%b expected 0", c, in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_done1: {done,ready}=%b expected 11", {done, in_ready});
        end
        @(posedge clk);
        push_frame(16'h000E, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= FRAME_LEN; c++) begin
            checks++;
            if ({in_ready, busy} !== 2'b01) begin
                errors++;
                $display("FAIL b2b_ready2: cycle %0d {ready,busy}=%b expected 01", c, {in_ready, busy});
            end
            @(negedge clk);
        end
        checks++;
        if ({done, 32'(exp_q.size())} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL b2b_done2: done=%b left=%0d expected 1 left=0", done, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_data = 16'h000C; in_parity = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        push_frame(16'h000C, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        // Cycle 26 after the handshake sits inside data bit 5 (a 0 for 16'h000C).
        repeat (25) @(negedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        checks++;
        if ({tx_out, busy} !== 2'b10) begin
            errors++;
            $display("FAIL async_reset: {tx,busy}=%b expected 10", {tx_out, busy});
        end
        #0.5 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
            errors++;
            $display("FAIL after_reset: {tx,busy,ready,done}=%b expected 1010", {tx_out, busy, in_ready, done});
        end
        test_frame(16'h5A3C, 1'b1, 1'b0);
    endtask

    task automatic test_cpb1();
        logic e;
        @(negedge clk);
        d1 = 16'hA5A5; p1 = 1'b0; v1 = 1'b1;
        @(posedge clk);
        for (int b = 0; b < DATA_W + 3; b++) exp1_q.push_back(frame_bit(16'hA5A5, 1'b0, b));
        $display("frame sent (cpb1): data=%h parity=%b", 16'hA5A5, 1'b0);
        @(negedge clk);
        v1 = 1'b0;
        for (int c = 1; c <= DATA_W + 3; c++) begin
            e = exp1_q.pop_front();
            checks++;
            if ({tx1, busy1} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL cpb1_bit: cycle %0d {tx,busy}=%b expected %b", c, {tx1, busy1}, {e, 1'b1});
            end
            @(negedge clk);
        end
        checks++;
        if ({done1, tx1, ready1} !== 3'b111) begin
            errors++;
            $display("FAIL cpb1_done: {done,tx,ready}=%b expected 111", {done1, tx1, ready1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame(16'h000C, 1'b0, 1'b0);
        test_frame(16'h000E, 1'b1, 1'b1);
        test_back_to_back();
        test_async_reset();
        test_cpb1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
